// File: rtl/res_scan_ctrl.sv
// Debug sweep controller for the conv1/conv2/conv3 result-capture tap.
// Walks an element range, steers the tap selects and streams captured bytes.
module res_scan_ctrl #(
  parameter int L1_IDX = 40,
  parameter int L1_NUM = 64,
  parameter int L2_IDX = 1152,
  parameter int L3_IDX = 36,
  parameter int L3_NUM = 32,
  parameter int LAT1   = 2,
  parameter int LAT2   = 1,
  parameter int LAT3   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  layer_sel,
  input  logic [11:0] elem_first,
  input  logic [11:0] elem_count,
  input  logic        conv1_valid_o_rescaled,
  input  logic        conv2_valid_o_rescaled,
  input  logic        conv3_valid_o_rescaled,
  input  logic [7:0]  conv1_res_test,
  input  logic [7:0]  conv2_res_test,
  input  logic [7:0]  conv3_res_test,
  output logic [5:0]  res_sel_1,
  output logic [5:0]  res_sel_1_num,
  output logic [10:0] res_sel_2,
  output logic [5:0]  res_sel_3,
  output logic [4:0]  res_sel_3_num,
  output logic [7:0]  dbg_data,
  output logic [11:0] dbg_elem,
  output logic        dbg_valid,
  output logic        dbg_last,
  input  logic        dbg_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ARM, S_WAIT,
    S_LAT, S_SAMPLE, S_EMIT
  } state_t;

  localparam logic [11:0] TOT1 = 12'(L1_IDX * L1_NUM);
  localparam logic [11:0] TOT2 = 12'(L2_IDX);
  localparam logic [11:0] TOT3 = 12'(L3_IDX * L3_NUM);

  state_t state, state_nxt;

  logic [1:0]  layer;
  logic [11:0] rem;
  logic [11:0] remaining;
  logic [11:0] e_cur;
  logic [10:0] idx;
  logic [5:0]  num;
  logic [5:0]  b1;
  logic [4:0]  b3;
  logic [1:0]  lat_cnt;

  logic [11:0] step;
  logic [11:0] tot;
  logic [10:0] idx_max;
  logic [1:0]  lat_init;
  logic [7:0]  tap;
  logic        match;
  logic        last;
  logic [11:0] req_tot;
  logic        start_ok;

  function automatic logic [11:0] tot_of(input logic [1:0] l);
    case (l)
      2'd1:    tot_of = TOT1;
      2'd2:    tot_of = TOT2;
      2'd3:    tot_of = TOT3;
      default: tot_of = 12'd0;
    endcase
  endfunction

  always_comb begin
    step     = 12'd0;
    tot      = 12'd0;
    idx_max  = 11'd0;
    lat_init = 2'd0;
    tap      = 8'd0;
    match    = 1'b0;
    unique case (1'b1)
      (layer == 2'd1): begin
        step     = 12'(L1_IDX);
        tot      = TOT1;
        idx_max  = 11'(L1_IDX - 1);
        lat_init = 2'(LAT1 - 1);
        tap      = conv1_res_test;
        match    = conv1_valid_o_rescaled
                   && (b1 == num);
      end
      (layer == 2'd2): begin
        step     = 12'(L2_IDX);
        tot      = TOT2;
        idx_max  = 11'(L2_IDX - 1);
        lat_init = 2'(LAT2 - 1);
        tap      = conv2_res_test;
        match    = conv2_valid_o_rescaled;
      end
      (layer == 2'd3): begin
        step     = 12'(L3_IDX);
        tot      = TOT3;
        idx_max  = 11'(L3_IDX - 1);
        lat_init = 2'(LAT3 - 1);
        tap      = conv3_res_test;
        match    = conv3_valid_o_rescaled
                   && (b3 == num[4:0]);
      end
      default: ;
    endcase
  end

  assign req_tot  = tot_of(layer_sel);
  assign start_ok = (layer_sel != 2'd0)
                    && (elem_count != 12'd0)
                    && (elem_first < req_tot);
  assign last     = (remaining == 12'd1)
                    || (e_cur == tot - 12'd1);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start && start_ok) state_nxt = S_SETUP;
      S_SETUP:  if (rem < step) state_nxt = S_ARM;
      S_ARM:    state_nxt = S_WAIT;
      S_WAIT:   if (match) state_nxt = S_LAT;
      S_LAT:    if (lat_cnt <= 2'd1) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = S_EMIT;
      S_EMIT:   if (dbg_ready)
                  state_nxt = dbg_last ? S_IDLE : S_ARM;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Beat mirrors run in every state so they stay locked to the tap.
  always_ff @(posedge clk) begin
    if (rst) begin
      b1 <= 6'd0;
      b3 <= 5'd0;
    end else begin
      if (conv1_valid_o_rescaled)
        b1 <= (b1 == 6'(L1_NUM - 1)) ? 6'd0 : b1 + 6'd1;
      if (conv3_valid_o_rescaled)
        b3 <= (b3 == 5'(L3_NUM - 1)) ? 5'd0 : b3 + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      layer         <= 2'd0;
      rem           <= 12'd0;
      remaining     <= 12'd0;
      e_cur         <= 12'd0;
      idx           <= 11'd0;
      num           <= 6'd0;
      lat_cnt       <= 2'd0;
      res_sel_1     <= 6'd0;
      res_sel_1_num <= 6'd0;
      res_sel_2     <= 11'd0;
      res_sel_3     <= 6'd0;
      res_sel_3_num <= 5'd0;
      dbg_data      <= 8'd0;
      dbg_elem      <= 12'd0;
      dbg_valid     <= 1'b0;
      dbg_last      <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (start_ok) begin
              layer     <= layer_sel;
              rem       <= elem_first;
              remaining <= elem_count;
              e_cur     <= elem_first;
              num       <= 6'd0;
            end else begin
              done <= 1'b1;
            end
          end
        end
        // Split the start index into beat/byte by repeated subtraction.
        S_SETUP: begin
          if (rem >= step) begin
            rem <= rem - step;
            num <= num + 6'd1;
          end else begin
            idx <= rem[10:0];
          end
        end
        S_ARM: begin
          unique case (layer)
            2'd1: begin
              res_sel_1     <= idx[5:0];
              res_sel_1_num <= num;
            end
            2'd2: res_sel_2 <= idx;
            2'd3: begin
              res_sel_3     <= idx[5:0];
              res_sel_3_num <= num[4:0];
            end
            default: ;
          endcase
        end
        S_WAIT: if (match) lat_cnt <= lat_init;
        S_LAT:  if (lat_cnt > 2'd1) lat_cnt <= lat_cnt - 2'd1;
        S_SAMPLE: begin
          dbg_data  <= tap;
          dbg_elem  <= e_cur;
          dbg_valid <= 1'b1;
          dbg_last  <= last;
        end
        S_EMIT: begin
          if (dbg_ready) begin
            dbg_valid <= 1'b0;
            dbg_last  <= 1'b0;
            if (dbg_last) begin
              done <= 1'b1;
            end else begin
              if (idx == idx_max) begin
                idx <= 11'd0;
                num <= num + 6'd1;
              end else begin
                idx <= idx + 11'd1;
              end
              e_cur     <= e_cur + 12'd1;
              remaining <= remaining - 12'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_res_scan_ctrl.sv
// Directed bench for res_scan_ctrl.
// Drives tap beats from a local beat model and checks the streamed bytes.
module tb_res_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  layer_sel;
  logic [11:0] elem_first;
  logic [11:0] elem_count;
  logic        v1, v2, v3;
  logic [7:0]  t1, t2, t3;
  logic [5:0]  res_sel_1;
  logic [5:0]  res_sel_1_num;
  logic [10:0] res_sel_2;
  logic [5:0]  res_sel_3;
  logic [4:0]  res_sel_3_num;
  logic [7:0]  dbg_data;
  logic [11:0] dbg_elem;
  logic        dbg_valid;
  logic        dbg_last;
  logic        dbg_ready;
  logic        busy;
  logic        done;

  int n_chk  = 0;
  int n_fail = 0;
  int mb1    = 0;
  int mb3    = 0;

  always #5 clk = ~clk;

  res_scan_ctrl dut (
    .clk                    (clk),
    .rst                    (rst),
    .start                  (start),
    .layer_sel              (layer_sel),
    .elem_first             (elem_first),
    .elem_count             (elem_count),
    .conv1_valid_o_rescaled (v1),
    .conv2_valid_o_rescaled (v2),
    .conv3_valid_o_rescaled (v3),
    .conv1_res_test         (t1),
    .conv2_res_test         (t2),
    .conv3_res_test         (t3),
    .res_sel_1              (res_sel_1),
    .res_sel_1_num          (res_sel_1_num),
    .res_sel_2              (res_sel_2),
    .res_sel_3              (res_sel_3),
    .res_sel_3_num          (res_sel_3_num),
    .dbg_data               (dbg_data),
    .dbg_elem               (dbg_elem),
    .dbg_valid              (dbg_valid),
    .dbg_last               (dbg_last),
    .dbg_ready              (dbg_ready),
    .busy                   (busy),
    .done                   (done)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go(input logic [1:0] l,
                    input int f, input int c);
    layer_sel  = l;
    elem_first = 12'(f);
    elem_count = 12'(c);
    start      = 1'b1;
    tick(1);
    start      = 1'b0;
  endtask

  // Beat every other cycle; return just after the matching beat's edge.
  task automatic hit(input int l, input int target);
    bit hit_ok;
    bit is_m;
    hit_ok = 0;
    for (int k = 0; k < 200 && !hit_ok; k++) begin
      is_m = (l == 1) ? (mb1 == target) :
             (l == 3) ? (mb3 == target) : 1'b1;
      v1 = (l == 1);
      v2 = (l == 2);
      v3 = (l == 3);
      tick(1);
      v1 = 1'b0;
      v2 = 1'b0;
      v3 = 1'b0;
      if (l == 1) mb1 = (mb1 + 1) % 64;
      if (l == 3) mb3 = (mb3 + 1) % 32;
      if (is_m) hit_ok = 1;
      else      tick(1);
    end
  endtask

  task automatic wait_valid(input string tag);
    for (int k = 0; k < 50 && !dbg_valid; k++) tick(1);
    check(tag, dbg_valid, 1'b1);
  endtask

  task automatic accept;
    dbg_ready = 1'b1;
    tick(1);
    dbg_ready = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    layer_sel  = 2'd0;
    elem_first = 12'd0;
    elem_count = 12'd0;
    v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
    t1 = 8'h00; t2 = 8'h00; t3 = 8'h00;
    dbg_ready  = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", dbg_valid, 1'b0);
    check("rst_sel1", res_sel_1, 6'd0);
    check("rst_data", dbg_data, 8'd0);

    // conv1 element 85 = beat 2, byte 5
    t1 = 8'hA5;
    go(2'd1, 85, 1);
    check("c1_busy", busy, 1'b1);
    tick(80);
    check("c1_sel", res_sel_1, 6'd5);
    check("c1_num", res_sel_1_num, 6'd2);
    dbg_ready = 1'b1;
    hit(1, 2);
    tick(1);
    check("c1_early", dbg_valid, 1'b0);
    tick(1);
    check("c1_valid", dbg_valid, 1'b1);
    check("c1_data", dbg_data, 8'hA5);
    check("c1_elem", dbg_elem, 12'd85);
    check("c1_last", dbg_last, 1'b1);
    tick(1);
    dbg_ready = 1'b0;
    check("c1_done", done, 1'b1);
    check("c1_idle", busy, 1'b0);
    check("c1_clr", dbg_valid, 1'b0);
    tick(1);
    check("c1_done1", done, 1'b0);

    // conv2 range past the end truncates at 1151
    t2 = 8'h3C;
    go(2'd2, 1150, 5);
    tick(80);
    check("c2_sel_a", res_sel_2, 11'd1150);
    hit(2, 0);
    wait_valid("c2_v_a");
    check("c2_elem_a", dbg_elem, 12'd1150);
    check("c2_last_a", dbg_last, 1'b0);
    check("c2_data_a", dbg_data, 8'h3C);
    accept;
    check("c2_nodone", done, 1'b0);
    tick(3);
    check("c2_sel_b", res_sel_2, 11'd1151);
    hit(2, 0);
    wait_valid("c2_v_b");
    check("c2_elem_b", dbg_elem, 12'd1151);
    check("c2_last_b", dbg_last, 1'b1);
    accept;
    check("c2_done", done, 1'b1);

    // conv3 wrap 35 -> (0,1) with a 7-cycle stall
    t3 = 8'h5A;
    go(2'd3, 35, 2);
    tick(80);
    check("c3_sel_a", res_sel_3, 6'd35);
    check("c3_num_a", res_sel_3_num, 5'd0);
    hit(3, 0);
    wait_valid("c3_v_a");
    t3 = 8'hFF;
    for (int i = 0; i < 7; i++) begin
      v3 = (i == 2 || i == 4);
      tick(1);
      if (v3) mb3 = (mb3 + 1) % 32;
      v3 = 1'b0;
      check("c3_hold_d", dbg_data, 8'h5A);
      check("c3_hold_e", dbg_elem, 12'd35);
    end
    check("c3_last_a", dbg_last, 1'b0);
    accept;
    tick(3);
    check("c3_sel_b", res_sel_3, 6'd0);
    check("c3_num_b", res_sel_3_num, 5'd1);
    hit(3, 1);
    wait_valid("c3_v_b");
    check("c3_elem_b", dbg_elem, 12'd36);
    check("c3_data_b", dbg_data, 8'hFF);
    check("c3_last_b", dbg_last, 1'b1);
    accept;
    check("c3_done", done, 1'b1);

    // rejected requests
    go(2'd0, 3, 3);
    check("bad_l_done", done, 1'b1);
    check("bad_l_busy", busy, 1'b0);
    tick(1);
    check("bad_l_pulse", done, 1'b0);
    go(2'd1, 0, 0);
    check("bad_c_done", done, 1'b1);
    check("bad_c_busy", busy, 1'b0);
    go(2'd2, 1152, 1);
    check("bad_f_done", done, 1'b1);
    check("bad_sel1", res_sel_1, 6'd5);
    check("bad_sel3", res_sel_3, 6'd0);

    // reset in LAT of a conv1 sweep
    t1 = 8'h11;
    go(2'd1, 0, 1);
    tick(80);
    hit(1, 0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    mb1 = 0;
    check("ab_busy", busy, 1'b0);
    check("ab_done", done, 1'b0);
    check("ab_valid", dbg_valid, 1'b0);
    check("ab_sel2", res_sel_2, 11'd0);
    check("ab_data", dbg_data, 8'd0);
    tick(2);
    check("ab_done2", done, 1'b0);
    check("ab_valid2", dbg_valid, 1'b0);
    t1 = 8'h77;
    go(2'd1, 45, 1);
    tick(80);
    check("rs_sel", res_sel_1, 6'd5);
    check("rs_num", res_sel_1_num, 6'd1);
    hit(1, 1);
    wait_valid("rs_v");
    check("rs_elem", dbg_elem, 12'd45);
    check("rs_data", dbg_data, 8'h77);
    accept;
    check("rs_done", done, 1'b1);

    // second start while busy is dropped
    go(2'd2, 10, 2);
    tick(5);
    go(2'd1, 0, 1);
    tick(80);
    check("bz_sel2", res_sel_2, 11'd10);
    hit(2, 0);
    wait_valid("bz_v_a");
    check("bz_elem_a", dbg_elem, 12'd10);
    check("bz_last_a", dbg_last, 1'b0);
    accept;
    tick(3);
    hit(2, 0);
    wait_valid("bz_v_b");
    check("bz_elem_b", dbg_elem, 12'd11);
    check("bz_last_b", dbg_last, 1'b1);
    accept;
    check("bz_done", done, 1'b1);
    check("bz_sel1", res_sel_1, 6'd5);
    tick(1);
    check("bz_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/res_scan_ctrl.md
Name: res_scan_ctrl

Overview:
- Debug sweep controller for the per-layer result-capture tap (conv1/conv2/conv3 rescaled outputs).
- Walks a requested range of output elements of one selected layer and drives the tap's select inputs for each element.
- Tracks the tap's valid-beat counters, samples the captured byte after the tap's fixed latency, and streams each byte out over a valid/ready debug port.
- Sits between the top-level debug/UART logic and the capture tap.

Parameters:
- L1_IDX, 40, conv1 bytes per valid beat
- L1_NUM, 64, conv1 beats per frame
- L2_IDX, 1152, conv2 bytes per valid beat (single-beat frame)
- L3_IDX, 36, conv3 bytes per valid beat
- L3_NUM, 32, conv3 beats per frame
- LAT1, 2, cycles from conv1 matching valid to tap conv1 byte stable
- LAT2, 1, cycles from conv2 valid to tap conv2 byte stable
- LAT3, 2, cycles from conv3 matching valid to tap conv3 byte stable

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request; ignored while busy
- layer_sel  in  2  1=conv1, 2=conv2, 3=conv3; 0 = invalid
- elem_first  in  12  first linear element index, latched at start
- elem_count  in  12  number of elements, latched at start
- conv1_valid_o_rescaled  in  1  conv1 beat valid (same net feeding the tap)
- conv2_valid_o_rescaled  in  1  conv2 beat valid
- conv3_valid_o_rescaled  in  1  conv3 beat valid
- conv1_res_test / conv2_res_test / conv3_res_test  in  8 each  captured bytes from the tap
- res_sel_1  out  6  conv1 byte index; res_sel_1_num  out 6  conv1 beat number
- res_sel_2  out  11  conv2 byte index
- res_sel_3  out  6  conv3 byte index; res_sel_3_num  out 5  conv3 beat number
- dbg_data  out  8  streamed byte
- dbg_elem  out  12  linear index of dbg_data
- dbg_valid  out  1  dbg_data valid
- dbg_last  out  1  high with final byte of the sweep
- dbg_ready  in  1  downstream accept
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep end

Behaviour:
- Reset: state IDLE; all outputs 0; internal beat counters 0. Reset mid-sweep aborts immediately, with no done pulse.
- Linear index:
  - conv1: e = num*L1_IDX + idx (total 2560).
  - conv2: e = idx (total 1152).
  - conv3: e = num*L3_IDX + idx (total 1152).
  - idx/num are derived by an incrementing counter pair, not by division.
- Beat mirrors:
  - b1 counts conv1 valids with wrap at L1_NUM-1 → 0.
  - b3 counts conv3 valids with wrap at L3_NUM-1 → 0.
  - Both update every cycle in all states, so they track the tap's internal counters.
- FSM:
  - IDLE: on start with layer_sel≠0 and elem_count≠0, latch layer, elem_first and elem_count, then go to SETUP. If layer_sel=0, elem_count=0 or elem_first≥total, pulse done for one cycle and stay IDLE.
  - SETUP: load the idx/num counters from elem_first; go to ARM.
  - ARM: drive the res_sel_* outputs for the current element. They are registered and held stable until SAMPLE completes. Go to WAIT.
  - WAIT: advance to LAT on a matching valid:
    - conv1: conv1 valid && b1 == current num.
    - conv2: any conv2 valid.
    - conv3: conv3 valid && b3 == current num.
    - Valids in ARM are not matches.
  - LAT: count down LATn−1 cycles, then go to SAMPLE. With LAT2=1, go straight to SAMPLE on the next cycle.
  - SAMPLE: register the selected layer's tap byte into dbg_data and the current e into dbg_elem. Set dbg_valid=1. Set dbg_last=1 if this is the last element, where last = remaining==1 or e==total−1. Go to EMIT.
  - EMIT: hold dbg_* until dbg_valid && dbg_ready. On handshake:
    - If last: clear dbg_valid, pulse done, go to IDLE.
    - Otherwise: advance idx (wrap to 0 and increment num at IDX−1), decrement remaining, clear dbg_valid, go to ARM.
- Element order: ascending e. A range past the layer end is truncated at total−1, and dbg_last fires there.
- busy = (state ≠ IDLE).
- start pulses while busy are dropped; no queuing.
- dbg_ready may be high before dbg_valid; data changes only after a completed handshake.

Test Plan:
- conv1, elem_first=85, count=1: expect res_sel_1=5, res_sel_1_num=2. After the b1==2 valid, dbg_data equals conv1_res_test 2 cycles later, with dbg_elem=85, dbg_last=1 and a done pulse.
- conv2, first=1150, count=5: expect 2 bytes, e=1150 and 1151, with dbg_last on 1151 (truncation); done follows the second handshake.
- conv3, first=35, count=2: expect idx/num wrap, giving (35, 0) then (0, 1). Each byte waits for the matching beat of the next frame if needed. Stall dbg_ready for 7 cycles; dbg_data and dbg_elem stay stable throughout.
- start with layer_sel=0, or count=0: expect a done pulse the next cycle, busy stays 0, res_sel_* unchanged.
- Assert rst during LAT of a conv1 sweep: next cycle IDLE, all outputs 0, no done. A new sweep then runs correctly with b1 resynchronised from 0.
- Second start while busy: ignored; the original sweep completes with unchanged elem_count.
